// File: rtl/layer_compositor_pkg.sv
// layer_compositor_pkg: shared types, constants and the lowest-set-bit helper
package layer_compositor_pkg;
  localparam int MAX_LAYERS = 64;
  localparam int MAX_IDW = $clog2(MAX_LAYERS);
  localparam int RGB_W_DEFAULT = 8;
  localparam logic [7:0] TRANSPARENT_DEFAULT = 8'hFF;
  typedef logic [RGB_W_DEFAULT-1:0] rgb_t;
  typedef struct packed {
    logic [MAX_IDW-1:0] idx;
    logic valid;
  } lowest_t;
  // Scans from the top so the lowest set index is the last one written
  function automatic lowest_t lowest_set(input logic [MAX_LAYERS-1:0] vec);
    lowest_t res;
    res = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--)
      if (vec[i]) begin
        res.idx = MAX_IDW'(i);
        res.valid = 1'b1;
      end
    return res;
  endfunction
endpackage

// File: rtl/layer_compositor_prio_encoder.sv
// prio_encoder: combinational lowest-set-bit encoder; index is 0 when nothing is set
module prio_encoder
  import layer_compositor_pkg::*;
#(
  parameter int LAYERS = 16,
  parameter int IDW = $clog2(LAYERS)
) (
  input  logic [LAYERS-1:0] i_vec,
  output logic [IDW-1:0]    o_idx,
  output logic              o_valid
);
  lowest_t w_res;
  always_comb begin
    w_res = lowest_set(MAX_LAYERS'(i_vec));
    o_idx = IDW'(w_res.idx);
    o_valid = w_res.valid;
  end
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority compositor with colour keying, blinking and
// per-frame collision flags of layer 0 against every other layer.
module layer_compositor
  import layer_compositor_pkg::*;
#(
  parameter int LAYERS = 16,
  parameter int RGB_W = RGB_W_DEFAULT,
  parameter logic [RGB_W-1:0] TRANSPARENT = RGB_W'(TRANSPARENT_DEFAULT),
  parameter bit USE_KEY = 1'b1,
  parameter int BLINK_LOG2 = 4,
  parameter int IDW = $clog2(LAYERS)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic [LAYERS-1:0]       layerDR,
  input  logic [LAYERS*RGB_W-1:0] layerRGB,
  input  logic [LAYERS-1:0]       layerEn,
  input  logic [LAYERS-1:0]       blinkMask,
  input  logic [RGB_W-1:0]        backGroundRGB,
  output logic [RGB_W-1:0]        RGBOut,
  output logic [IDW-1:0]          topLayer,
  output logic                    topValid,
  output logic [LAYERS-1:0]       hitFlags,
  output logic                    hitValid
);
  logic [BLINK_LOG2-1:0]   r_frame_cnt;
  logic [LAYERS-1:0]       r_eff;
  logic [LAYERS*RGB_W-1:0] r_rgb;
  logic [RGB_W-1:0]        r_bg;
  logic                    r_sof;
  logic [LAYERS-1:0]       r_hit_acc;
  logic [LAYERS-1:0]       w_eff;
  logic [LAYERS-1:0]       w_ovl;
  logic [IDW-1:0]          w_idx;
  logic                    w_valid;
  logic                    w_blink_phase;
  assign w_blink_phase = r_frame_cnt[BLINK_LOG2-1];
  always_comb begin
    w_eff = '0;
    for (int i = 0; i < LAYERS; i++)
      w_eff[i] = layerDR[i] & layerEn[i]
               & !(USE_KEY && layerRGB[i*RGB_W +: RGB_W] == TRANSPARENT)
               & !(blinkMask[i] & w_blink_phase);
  end
  // Layer 0 against itself is masked off so bit 0 never flags
  assign w_ovl = r_eff[0] ? {r_eff[LAYERS-1:1], 1'b0} : '0;
  prio_encoder #(.LAYERS(LAYERS), .IDW(IDW)) u_prio (
    .i_vec  (r_eff),
    .o_idx  (w_idx),
    .o_valid(w_valid)
  );
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= '0;
      r_eff <= '0;
      r_rgb <= '0;
      r_bg <= '0;
      r_sof <= 1'b0;
      r_hit_acc <= '0;
      RGBOut <= '0;
      topLayer <= '0;
      topValid <= 1'b0;
      hitFlags <= '0;
      hitValid <= 1'b0;
    end else begin
      r_frame_cnt <= r_frame_cnt + BLINK_LOG2'(startOfFrame);
      r_eff <= w_eff;
      r_rgb <= layerRGB;
      r_bg <= backGroundRGB;
      r_sof <= startOfFrame;
      RGBOut <= w_valid ? r_rgb[w_idx*RGB_W +: RGB_W] : r_bg;
      topLayer <= w_idx;
      topValid <= w_valid;
      // An overlap coincident with the frame pulse seeds the new frame's accumulator
      r_hit_acc <= r_sof ? w_ovl : (r_hit_acc | w_ovl);
      hitValid <= r_sof;
      if (r_sof) hitFlags <= r_hit_acc;
    end
  end
endmodule

// File: tb/tb_layer_compositor.sv
// tb_layer_compositor: directed stimulus with a reference model feeding an expected-result queue
module tb_layer_compositor;
  logic         clk = 1'b0;
  logic         resetN = 1'b0;
  logic         startOfFrame;
  logic [15:0]  layerDR;
  logic [127:0] layerRGB;
  logic [15:0]  layerEn;
  logic [15:0]  blinkMask;
  logic [7:0]   backGroundRGB;
  logic [7:0]   RGBOut;
  logic [3:0]   topLayer;
  logic         topValid;
  logic [15:0]  hitFlags;
  logic         hitValid;

  typedef struct {
    logic [7:0]  rgb;
    logic [3:0]  top;
    logic        tv;
    logic [15:0] hf;
    logic        hv;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;
  int m_fc;
  logic [15:0] m_acc;
  logic [15:0] m_flags;

  layer_compositor #(.LAYERS(16), .RGB_W(8), .TRANSPARENT(8'hFF), .USE_KEY(1'b1), .BLINK_LOG2(2)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .layerDR      (layerDR),
    .layerRGB     (layerRGB),
    .layerEn      (layerEn),
    .blinkMask    (blinkMask),
    .backGroundRGB(backGroundRGB),
    .RGBOut       (RGBOut),
    .topLayer     (topLayer),
    .topValid     (topValid),
    .hitFlags     (hitFlags),
    .hitValid     (hitValid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // Model the current inputs, queue the result, advance one pixel and check the one due now
  task automatic tick();
    exp_t e;
    logic [15:0] eff;
    logic [15:0] ovl;
    logic phase;
    phase = (m_fc % 4) >= 2;
    for (int i = 0; i < 16; i++)
      eff[i] = layerDR[i] && layerEn[i] && (layerRGB[i*8 +: 8] != 8'hFF) && !(blinkMask[i] && phase);
    e.tv = 1'b0;
    e.top = 4'd0;
    e.rgb = backGroundRGB;
    for (int i = 15; i >= 0; i--)
      if (eff[i]) begin
        e.tv = 1'b1;
        e.top = 4'(i);
        e.rgb = layerRGB[i*8 +: 8];
      end
    ovl = '0;
    for (int i = 1; i < 16; i++) ovl[i] = eff[0] && eff[i];
    if (startOfFrame) begin
      e.hv = 1'b1;
      e.hf = m_acc;
      m_flags = m_acc;
      m_acc = ovl;
      m_fc++;
    end else begin
      e.hv = 1'b0;
      e.hf = m_flags;
      m_acc = m_acc | ovl;
    end
    q.push_back(e);
    @(negedge clk);
    if (q.size() >= 2) begin
      e = q.pop_front();
      chk("rgb", 32'(RGBOut), 32'(e.rgb));
      chk("top", 32'(topLayer), 32'(e.top));
      chk("topValid", 32'(topValid), 32'(e.tv));
      chk("hitFlags", 32'(hitFlags), 32'(e.hf));
      chk("hitValid", 32'(hitValid), 32'(e.hv));
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0;
    startOfFrame = 1'($urandom);
    layerDR = 16'($urandom);
    layerRGB = {$urandom, $urandom, $urandom, $urandom};
    layerEn = 16'($urandom);
    blinkMask = 16'($urandom);
    backGroundRGB = 8'($urandom);
    q.delete();
    m_fc = 0;
    m_acc = '0;
    m_flags = '0;
    #1;
    chk("rst_rgb", 32'(RGBOut), 32'h0);
    chk("rst_topValid", 32'(topValid), 32'h0);
    chk("rst_hitFlags", 32'(hitFlags), 32'h0);
    chk("rst_hitValid", 32'(hitValid), 32'h0);
    repeat (2) @(negedge clk);
    chk("rst_hold_rgb", 32'(RGBOut), 32'h0);
    chk("rst_hold_topLayer", 32'(topLayer), 32'h0);
    startOfFrame = 1'b0;
    layerDR = '0;
    layerRGB = '0;
    layerEn = '1;
    blinkMask = '0;
    backGroundRGB = 8'h12;
    resetN = 1'b1;
  endtask

  initial begin
    do_reset();
    tick();
    tick();
    chk("bg_after_reset", 32'(RGBOut), 32'h12);

    // Priority and latency
    layerRGB[3*8 +: 8] = 8'hA0;
    layerRGB[7*8 +: 8] = 8'h0C;
    layerDR = 16'h0088;
    tick();
    layerDR = 16'h0080;
    tick();
    chk("prio_rgb", 32'(RGBOut), 32'hA0);
    chk("prio_top", 32'(topLayer), 32'd3);
    layerDR = '0;
    tick();
    chk("next_rgb", 32'(RGBOut), 32'h0C);
    chk("next_top", 32'(topLayer), 32'd7);
    tick();

    // Colour key and enable
    layerRGB[2*8 +: 8] = 8'hFF;
    layerRGB[5*8 +: 8] = 8'h33;
    layerDR = 16'h0024;
    tick();
    tick();
    chk("key_rgb", 32'(RGBOut), 32'h33);
    layerEn[5] = 1'b0;
    tick();
    tick();
    chk("disabled_rgb", 32'(RGBOut), 32'h12);
    chk("disabled_valid", 32'(topValid), 32'h0);

    // Blink over eight short frames
    do_reset();
    layerRGB[1*8 +: 8] = 8'h55;
    blinkMask[1] = 1'b1;
    layerDR = 16'h0002;
    for (int f = 0; f < 8; f++) begin
      tick();
      tick();
      tick();
      chk($sformatf("blink_f%0d", f), 32'(RGBOut), (f % 4 < 2) ? 32'h55 : 32'h12);
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
    end

    // Collision reporting
    do_reset();
    tick();
    tick();
    layerRGB[0*8 +: 8] = 8'h40;
    layerRGB[4*8 +: 8] = 8'h44;
    layerDR = 16'h0011;
    tick();
    layerDR = '0;
    tick();
    tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    chk("hit_pulse", 32'(hitValid), 32'h1);
    chk("hit_flags", 32'(hitFlags), 32'h0010);
    tick();
    chk("hit_pulse_end", 32'(hitValid), 32'h0);
    chk("hit_flags_held", 32'(hitFlags), 32'h0010);
    repeat (3) tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    chk("quiet_frame_flags", 32'(hitFlags), 32'h0);
    chk("quiet_frame_pulse", 32'(hitValid), 32'h1);

    // Overlap coincident with the frame pulse belongs to the next frame
    layerDR = 16'h0011;
    startOfFrame = 1'b1;
    tick();
    layerDR = '0;
    startOfFrame = 1'b0;
    tick();
    chk("edge_current_flags", 32'(hitFlags), 32'h0);
    chk("edge_current_pulse", 32'(hitValid), 32'h1);
    repeat (3) tick();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
    chk("edge_next_flags", 32'(hitFlags), 32'h0010);
    chk("edge_next_pulse", 32'(hitValid), 32'h1);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
